// File: rtl/conv5x5_pkg.sv
// conv5x5_pkg
// Shared definitions for the 5x5 window generator and convolution datapath:
// kernel size, element count, the window element bit-offset helper and the
// window generator FSM state type.
package conv5x5_pkg;

    localparam int K  = 5;        // kernel / window edge length
    localparam int KK = K * K;    // elements per window

    typedef enum logic {
        S_FILL = 1'b0,            // fewer than K-1 lines buffered
        S_RUN  = 1'b1             // window rows all inside the current frame
    } state_t;

    // Bit offset of window element (r,c) in a flat window of n-bit pixels.
    function automatic int win_off(input int r, input int c, input int n);
        return (r * K + c) * n;
    endfunction

endpackage

// File: rtl/window_5x5_gen_if.sv
// window_5x5_gen_if
// Pixel-stream input and window output bundle of window_5x5_gen.
//   i_valid / i_sof / i_data : raster pixel stream into the generator
//   o_valid / o_win          : registered window strobe and 25-pixel window
//   o_row / o_col            : window-centre position (only with WIN_POS_EN)
// Modports: master = stream source / window sink, slave = the generator.
// Optional feature macro: WIN_POS_EN.
interface window_5x5_gen_if
    import conv5x5_pkg::*;
#(
    parameter int N = 8
`ifdef WIN_POS_EN
    ,
    parameter int W = 32,
    parameter int H = 32
`endif
) ();

    logic              i_valid;
    logic              i_sof;
    logic [N-1:0]      i_data;
    logic              o_valid;
    logic [KK*N-1:0]   o_win;
`ifdef WIN_POS_EN
    logic [$clog2(H)-1:0] o_row;
    logic [$clog2(W)-1:0] o_col;
`endif

    modport master (
        output i_valid, i_sof, i_data,
`ifdef WIN_POS_EN
        input  o_row, o_col,
`endif
        input  o_valid, o_win
    );

    modport slave (
        input  i_valid, i_sof, i_data,
`ifdef WIN_POS_EN
        output o_row, o_col,
`endif
        output o_valid, o_win
    );

endinterface

// File: rtl/line_buf.sv
// line_buf
// W-deep, N-bit enabled delay line: o_data is the value written W enables ago.
// Ports: i_clk (rising edge), i_rst_n (synchronous, active-low, clears the
// line to zero), i_en (shift enable), i_data (input pixel), o_data (oldest pixel).
module line_buf #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [N-1:0] i_data,
    output logic [N-1:0] o_data
);

    logic [N-1:0] mem_r [W];

    // Shift register: holds while i_en is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < W; i++) begin
                mem_r[i] <= '0;
            end
        end else if (i_en) begin
            mem_r[0] <= i_data;
            for (int i = 1; i < W; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    assign o_data = mem_r[W-1];

endmodule

// File: rtl/window_5x5_gen.sv
// window_5x5_gen
// Streaming 5x5 window generator. Tracks the raster position of each accepted
// pixel, buffers four previous lines, and emits the 5x5 neighbourhood ending
// at the accepted pixel, qualified once the window lies fully inside the frame.
// Ports: i_clk (rising edge), i_rst_n (synchronous, active-low),
//        bus (window_5x5_gen_if.slave): pixel stream in, window/strobe out.
// Optional feature macro: WIN_POS_EN adds registered window-centre o_row/o_col.
module window_5x5_gen
    import conv5x5_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32,
    parameter int H = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    window_5x5_gen_if.slave   bus
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic [CW-1:0] col_r, cur_col_s, col_next_s;
    logic [RW-1:0] row_r, cur_row_s, row_next_s;
    logic          accept_s;
    logic          row_wrap_s;
    logic          qualify_s;
    state_t        state_r, state_next_s;
    logic [N-1:0]  chain_s [K];      // chain_s[0] = i_data, chain_s[k+1] = LBk output
    logic [N-1:0]  win_r [K][K];
    logic          valid_r;

    assign accept_s = bus.i_valid;

    // Position of the pixel being accepted (i_sof forces it to (0,0)) and the
    // position the counters advance to afterwards.
    always_comb begin
        cur_col_s  = col_r;
        cur_row_s  = row_r;
        col_next_s = col_r;
        row_next_s = row_r;
        row_wrap_s = 1'b0;
        if (bus.i_valid && bus.i_sof) begin
            cur_col_s = '0;
            cur_row_s = '0;
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        if (cur_col_s == CW'(W - 1)) begin
            col_next_s = '0;
            if (cur_row_s == RW'(H - 1)) begin
                row_next_s = '0;
                row_wrap_s = 1'b1;
            end else begin
                row_next_s = cur_row_s + RW'(1);
            end
        end else begin
            col_next_s = cur_col_s + CW'(1);
            row_next_s = cur_row_s;
        end
    end

    // Raster position counters, advancing only on accepted pixels.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            col_r <= col_next_s;
            row_r <= row_next_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= S_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and window qualification. S_RUN means rows R-4..R all
    // belong to the current frame, so only the column condition remains.
    always_comb begin
        state_next_s = state_r;
        qualify_s    = 1'b0;
        case (state_r)
            S_FILL: begin
                if (accept_s && (cur_row_s == RW'(4)) && (cur_col_s == CW'(0))) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_FILL;
                end
            end
            S_RUN: begin
                qualify_s = accept_s && !bus.i_sof && (cur_col_s >= CW'(4));
                if (accept_s && (bus.i_sof || row_wrap_s)) begin
                    state_next_s = S_FILL;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            default: begin
                state_next_s = S_FILL;
                qualify_s    = 1'b0;
            end
        endcase
    end

    assign chain_s[0] = bus.i_data;

    genvar k;
    generate
        for (k = 0; k < K - 1; k++) begin : g_lb
            line_buf #(.N(N), .W(W)) u_line_buf (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_en    (accept_s),
                .i_data  (chain_s[k]),
                .o_data  (chain_s[k+1])
            );
        end
    endgenerate

    // Window array: shift left one column, new right column from the line
    // buffers (oldest line on top) with the incoming pixel at the bottom.
    // Being registered, it directly serves as the o_win output register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_r[r][c] <= '0;
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_r[r][c] <= win_r[r][c+1];
                end
                win_r[r][K-1] <= chain_s[K-1-r];
            end
        end
    end

    // Window valid strobe: one pulse per qualifying accepted pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= qualify_s;
        end
    end

    assign bus.o_valid = valid_r;

    genvar gr, gc;
    generate
        for (gr = 0; gr < K; gr++) begin : g_row
            for (gc = 0; gc < K; gc++) begin : g_col
                localparam int OFF = win_off(gr, gc, N);
                assign bus.o_win[OFF +: N] = win_r[gr][gc];
            end
        end
    endgenerate

`ifdef WIN_POS_EN
    logic [RW-1:0] win_row_r;
    logic [CW-1:0] win_col_r;

    // Window-centre position, captured together with the valid strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            win_row_r <= '0;
            win_col_r <= '0;
        end else if (qualify_s) begin
            win_row_r <= cur_row_s - RW'(2);
            win_col_r <= cur_col_s - CW'(2);
        end
    end

    assign bus.o_row = win_row_r;
    assign bus.o_col = win_col_r;
`endif

endmodule

// File: tb/tb_window_5x5_gen.sv
// tb_window_5x5_gen
// Self-checking bench for window_5x5_gen (W=8, H=8, N=8). A reference model
// stores accepted pixels in a 2-D image indexed by raster position and builds
// each expected window directly from that image.
module tb_window_5x5_gen;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int WB = 25 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_5x5_gen_if #(.N(N)
`ifdef WIN_POS_EN
        , .W(W), .H(H)
`endif
    ) bus ();

    window_5x5_gen #(.N(N), .W(W), .H(H)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int img [H][W];
    int mrow = 0;
    int mcol = 0;
    int sec_pulses = 0;
    logic [WB-1:0] first_win;
    logic [WB-1:0] last_win;

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] elem(input logic [WB-1:0] w, input int r, input int c);
        return WB'(w[(r * 5 + c) * N +: N]);
    endfunction

    // One clock: drive inputs, advance the model, check outputs #1 after the edge.
    task automatic step(input logic v, input logic s, input logic [N-1:0] d, input logic rn);
        logic          ev;
        logic [WB-1:0] ew;
        int            er, ec;
        bus.i_valid = v;
        bus.i_sof   = s;
        bus.i_data  = d;
        rst_n       = rn;
        @(posedge clk);
        #1;
        ev = 1'b0;
        ew = '0;
        er = 0;
        ec = 0;
        if (!rn) begin
            mrow = 0;
            mcol = 0;
        end else if (v) begin
            if (s) begin
                mrow = 0;
                mcol = 0;
            end
            img[mrow][mcol] = int'(d);
            if (mrow >= 4 && mcol >= 4) begin
                ev = 1'b1;
                for (int r = 0; r < 5; r++) begin
                    for (int c = 0; c < 5; c++) begin
                        ew[(r * 5 + c) * N +: N] = N'(img[mrow - 4 + r][mcol - 4 + c]);
                    end
                end
                er = mrow - 2;
                ec = mcol - 2;
            end
            mcol++;
            if (mcol == W) begin
                mcol = 0;
                mrow = (mrow + 1) % H;
            end
        end
        chk("o_valid", WB'(bus.o_valid), WB'(ev));
        if (!rn) begin
            chk("o_win_rst", bus.o_win, '0);
        end
        if (ev) begin
            chk("o_win", bus.o_win, ew);
`ifdef WIN_POS_EN
            chk("o_row", WB'(bus.o_row), WB'(er));
            chk("o_col", WB'(bus.o_col), WB'(ec));
`endif
        end
        if (bus.o_valid === 1'b1) begin
            if (sec_pulses == 0) first_win = bus.o_win;
            last_win = bus.o_win;
            sec_pulses++;
        end
    endtask

    // Full frame of pixel value row*8+col, with gap idle cycles after each pixel.
    task automatic frame_seq(input int gap);
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, 1'b0, N'(p), 1'b1);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, N'($urandom), 1'b1);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_data  = '0;

        // Reset held low with i_valid toggling.
        for (int i = 0; i < 3; i++) step(i[0], 1'b0, N'($urandom), 1'b0);

        // One frame, continuous.
        sec_pulses = 0;
        frame_seq(0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("cont_pulses", WB'(sec_pulses), WB'(16));
        chk("cont_first00", elem(first_win, 0, 0), WB'(0));
        chk("cont_first22", elem(first_win, 2, 2), WB'(18));
        chk("cont_first44", elem(first_win, 4, 4), WB'(36));
        chk("cont_last00", elem(last_win, 0, 0), WB'(27));
        chk("cont_last44", elem(last_win, 4, 4), WB'(63));

        // Same frame, every other cycle.
        sec_pulses = 0;
        frame_seq(1);
        chk("gap_pulses", WB'(sec_pulses), WB'(16));
        chk("gap_first22", elem(first_win, 2, 2), WB'(18));
        chk("gap_last00", elem(last_win, 0, 0), WB'(27));

        // i_sof at pixel (5,3).
        for (int p = 0; p < 5 * W + 3; p++) step(1'b1, 1'b0, N'(p), 1'b1);
        step(1'b0, 1'b1, 8'hAA, 1'b1);
        sec_pulses = 0;
        step(1'b1, 1'b1, 8'd200, 1'b1);
        for (int p = 1; p < W * H; p++) step(1'b1, 1'b0, N'($urandom), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("sof_pulses", WB'(sec_pulses), WB'(16));
        chk("sof_first00", elem(first_win, 0, 0), WB'(200));

        // Two frames back-to-back without i_sof.
        sec_pulses = 0;
        frame_seq(0);
        chk("b2b_pulses1", WB'(sec_pulses), WB'(16));
        sec_pulses = 0;
        frame_seq(0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("b2b_pulses2", WB'(sec_pulses), WB'(16));
        chk("b2b_first00", elem(first_win, 0, 0), WB'(0));
        chk("b2b_first44", elem(first_win, 4, 4), WB'(36));

        // Reset one cycle after accepting (6,2).
        for (int p = 0; p <= 6 * W + 2; p++) step(1'b1, 1'b0, N'(p), 1'b1);
        step(1'b1, 1'b0, N'($urandom), 1'b0);
        sec_pulses = 0;
        step(1'b0, 1'b0, '0, 1'b1);
        frame_seq(0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("rst_pulses", WB'(sec_pulses), WB'(16));

        // Random stream with occasional i_sof and reset.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0,
                 N'($urandom), $urandom_range(0, 399) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
